ddr_test_seq_ctrl: RTL

//  Multi-channel DDR traffic sequencer for the example design.

---
 rtl/ddr_test_seq_ctrl_if.sv | 26 ++
 rtl/ddr_test_seq_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ddr_test_seq_ctrl_if.sv
// Engine-side handshake bundle of the DDR traffic sequencer.
// The master side is the sequencer; the slave side is the set of per-channel init/wr/rd engines.
interface ddr_test_seq_ctrl_if #(
  parameter int NUM_CH          = 2,
  parameter int CTRL_ADDR_WIDTH = 28
);
  logic [NUM_CH-1:0]          init_start;
  logic [NUM_CH-1:0]          init_done;
  logic [NUM_CH-1:0]          write_en;
  logic [NUM_CH-1:0]          write_done_p;
  logic [NUM_CH-1:0]          read_en;
  logic [NUM_CH-1:0]          read_done_p;
  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr;
  logic [3:0]                 random_axi_id;
  logic [3:0]                 random_axi_len;
  logic [2:0]                 active_ch;

  modport master (
    output init_start, write_en, read_en, random_rw_addr, random_axi_id, random_axi_len, active_ch,
    input  init_done, write_done_p, read_done_p
  );
  modport slave (
    input  init_start, write_en, read_en, random_rw_addr, random_axi_id, random_axi_len, active_ch,
    output init_done, write_done_p, read_done_p
  );
endinterface

// File: rtl/ddr_test_seq_ctrl.sv
// Round-robin DDR traffic sequencer: picks W/R per mode, drives the engines of one channel
// at a time, draws address/id/len from a 64-bit LFSR, and stops on run length, error or watchdog.
module ddr_test_seq_ctrl #(
  parameter int          CTRL_ADDR_WIDTH = 28,
  parameter int          MEM_SPACE_AW    = 18,
  parameter int          ADDR_ALIGN      = 7,
  parameter int          NUM_CH          = 2,
  parameter int          OPCNT_W         = 32,
  parameter int          TIMEOUT_CYC     = 65536,
  parameter logic [63:0] LFSR_SEED       = 64'h1234_5678_9abc_def0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ddrc_init_done,
  input  logic               test_start,
  input  logic [1:0]         mode,
  input  logic [OPCNT_W-1:0] run_len,
  input  logic               stop_on_err,
  input  logic               err_in,
  ddr_test_seq_ctrl_if.master eng,
  output logic [OPCNT_W-1:0] op_cnt,
  output logic               test_done,
  output logic               test_fail,
  output logic               timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int LA_W = CTRL_ADDR_WIDTH - ADDR_ALIGN;
  localparam logic [CTRL_ADDR_WIDTH-1:0] ADDR_MASK =
    CTRL_ADDR_WIDTH'((65'd1 << MEM_SPACE_AW) - 65'd1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WR, S_RD, S_NEXT, S_DONE, S_FAIL} state_t;

  state_t              state, state_d;
  logic [63:0]         lfsr;
  logic [2:0]          ch;
  logic                alt_w;
  logic [OPCNT_W-1:0]  run_len_q;
  logic [WD_W-1:0]     wd_cnt;
  logic [NUM_CH-1:0]   ch_oh, wr_en_q, rd_en_q;
  logic                start_ok, err_hit, wd_hit, wr_ack, rd_ack, op_wr, in_op, in_wd;
  logic                load, ack, adv, tmo, lfsr_fb;

  assign ch_oh    = NUM_CH'(1) << ch;
  assign start_ok = test_start & ddrc_init_done;
  assign err_hit  = err_in & stop_on_err;
  assign wd_hit   = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign wr_ack   = |(eng.write_done_p & ch_oh);
  assign rd_ack   = |(eng.read_done_p & ch_oh);
  assign lfsr_fb  = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];
  assign in_op    = (state == S_WR) || (state == S_RD);
  assign in_wd    = in_op || (state == S_INIT);

  // Alt mode: alt_w is the phase of the current op, so NEXT proposes its complement.
  always_comb begin
    op_wr = 1'b0;
    unique case (mode)
      2'b00:   op_wr = lfsr[63];
      2'b01:   op_wr = (state == S_NEXT) ? ~alt_w : alt_w;
      2'b10:   op_wr = 1'b1;
      default: op_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    ack     = 1'b0;
    adv     = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_FAIL: if (start_ok) begin state_d = S_INIT; load = 1'b1; end
      S_INIT: begin
        if (err_hit)               state_d = S_FAIL;
        else if (&eng.init_done)   state_d = op_wr ? S_WR : S_RD;
        else if (wd_hit) begin     state_d = S_FAIL; tmo = 1'b1; end
      end
      S_WR, S_RD: begin
        if (err_hit)                                          state_d = S_FAIL;
        else if ((state == S_WR) ? wr_ack : rd_ack) begin     state_d = S_NEXT; ack = 1'b1; end
        else if (wd_hit) begin                                state_d = S_FAIL; tmo = 1'b1; end
      end
      S_NEXT: begin
        if (err_hit)                                     state_d = S_FAIL;
        else if (run_len_q != '0 && op_cnt == run_len_q) state_d = S_DONE;
        else begin                                       state_d = op_wr ? S_WR : S_RD; adv = 1'b1; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= LFSR_SEED;
      ch          <= '0;
      alt_w       <= 1'b1;
      run_len_q   <= '0;
      op_cnt      <= '0;
      wd_cnt      <= '0;
      wr_en_q     <= '0;
      rd_en_q     <= '0;
      test_done   <= 1'b0;
      test_fail   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (load) begin
        lfsr        <= LFSR_SEED;
        ch          <= '0;
        alt_w       <= 1'b1;
        run_len_q   <= run_len;
        op_cnt      <= '0;
        test_done   <= 1'b0;
        test_fail   <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (ack) begin
        op_cnt <= op_cnt + 1'b1;
        lfsr   <= {lfsr[62:0], lfsr_fb};
      end
      if (adv) begin
        ch    <= (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
        alt_w <= ~alt_w;
      end
      if (state_d == S_DONE && state != S_DONE) test_done <= 1'b1;
      if (state_d == S_FAIL && state != S_FAIL) begin
        test_fail   <= 1'b1;
        timeout_err <= tmo;
      end
      if (state_d != state && state_d inside {S_INIT, S_WR, S_RD}) wd_cnt <= '0;
      else if (in_wd)                                               wd_cnt <= wd_cnt + 1'b1;
      // Enables rise one cycle after entry and drop on the edge that leaves the op state.
      wr_en_q <= (state == S_WR && state_d == S_WR) ? ch_oh : '0;
      rd_en_q <= (state == S_RD && state_d == S_RD) ? ch_oh : '0;
    end
  end

  assign eng.init_start     = {NUM_CH{state == S_INIT}};
  assign eng.write_en       = wr_en_q;
  assign eng.read_en        = rd_en_q;
  assign eng.active_ch      = ch;
  assign eng.random_rw_addr = in_op ? ({lfsr[LA_W-1:0], {ADDR_ALIGN{1'b0}}} & ADDR_MASK) : '0;
  assign eng.random_axi_id  = in_op ? lfsr[43:40] : 4'd0;
  assign eng.random_axi_len = in_op ? lfsr[47:44] : 4'd0;
endmodule
